// File: rtl/input_conditioner_pkg.sv
// ic_pkg: shared defaults and EXT_MODE encodings for the input conditioner
// Holds the default channel count, debounce length and stretch length,
// plus the two ext trigger encodings used by ic_channel and the top.
package ic_pkg;
    localparam int IC_N_CH     = 4;
    localparam int IC_DEB_LEN  = 4;
    localparam int IC_EXT_LEN  = 4;
    localparam int IC_EXT_RISE = 0;
    localparam int IC_EXT_BOTH = 1;
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: bundle of raw inputs and conditioned outputs
// Signals (all N_CH wide):
//   in    - raw per-channel inputs
//   level - debounced level
//   rise  - one-cycle pulse on debounced 0->1
//   fall  - one-cycle pulse on debounced 1->0
//   ext   - stretched trigger pulse
// Modports: master drives in and observes outputs; slave is the conditioner.
interface input_conditioner_if import ic_pkg::*; #(
    parameter int N_CH = IC_N_CH
);
    logic [N_CH-1:0] in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] ext;
    modport master (output in, input level, rise, fall, ext);
    modport slave  (input in, output level, rise, fall, ext);
endinterface

// File: rtl/input_conditioner_channel.sv
// ic_channel: single-channel synchronize, debounce, edge detect and pulse stretch
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   in_i      - raw input
//   level_o   - debounced level
//   rise_o    - registered pulse in the first cycle level reads 1
//   fall_o    - registered pulse in the first cycle level reads 0
//   ext_o     - stretched trigger, high EXT_LEN cycles after the last trigger
// Macro INPUT_CONDITIONER_SYNC_EN inserts a 2-flop synchronizer before the
// debounce sampler; without it in_i must already be synchronous to clk.
module ic_channel import ic_pkg::*; #(
    parameter int DEB_LEN  = IC_DEB_LEN,
    parameter int EXT_LEN  = IC_EXT_LEN,
    parameter int EXT_MODE = IC_EXT_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic ext_o
);
    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int EW = $clog2(EXT_LEN + 1);
    // the counter only ever holds 0..DEB_LEN-1; the edge that would reach
    // DEB_LEN flips the level instead
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LEN - 1);
    localparam logic [EW-1:0] EXT_LOAD = EW'(EXT_LEN);
    logic sample;
`ifdef INPUT_CONDITIONER_SYNC_EN
    logic sync1_q, sync2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {sync1_q, sync2_q} <= 2'b00;
        else     {sync1_q, sync2_q} <= {in_i, sync1_q};
    end
    assign sample = sync2_q;
`else
    assign sample = in_i;
`endif
    logic [DW-1:0] deb_q, deb_d;
    logic [EW-1:0] ext_q, ext_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic diff, flip, trig;
    always_comb begin
        diff    = sample != level_q;
        flip    = diff && (deb_q == DEB_LAST);
        deb_d   = (diff && !flip) ? deb_q + 1'b1 : '0;
        level_d = flip ? sample : level_q;
        rise_d  = flip && sample;
        fall_d  = flip && !sample;
        trig    = rise_d || ((EXT_MODE == IC_EXT_BOTH) && fall_d);
        // retrigger reloads rather than accumulates; decrement saturates at 0
        ext_d   = trig ? EXT_LOAD : ((ext_q != '0) ? ext_q - 1'b1 : '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q   <= '0;
            ext_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            ext_q   <= ext_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign ext_o   = ext_q != '0;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: N_CH independent debounce / edge / stretch channels
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - input_conditioner_if slave: in, level, rise, fall, ext
// Parameters: N_CH, DEB_LEN, EXT_LEN, EXT_MODE (IC_EXT_RISE / IC_EXT_BOTH).
// Macro INPUT_CONDITIONER_SYNC_EN adds a 2-flop synchronizer per channel.
module input_conditioner import ic_pkg::*; #(
    parameter int N_CH     = IC_N_CH,
    parameter int DEB_LEN  = IC_DEB_LEN,
    parameter int EXT_LEN  = IC_EXT_LEN,
    parameter int EXT_MODE = IC_EXT_RISE
) (
    input logic clk,
    input logic rst,
    input_conditioner_if.slave bus
);
    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_ch
        ic_channel #(
            .DEB_LEN (DEB_LEN),
            .EXT_LEN (EXT_LEN),
            .EXT_MODE(EXT_MODE)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_i   (bus.in[i]),
            .level_o(bus.level[i]),
            .rise_o (bus.rise[i]),
            .fall_o (bus.fall[i]),
            .ext_o  (bus.ext[i])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner against a history-based model
module tb_input_conditioner;
    import ic_pkg::*;
`ifdef INPUT_CONDITIONER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    input_conditioner_if #(.N_CH(4)) if_a ();
    input_conditioner_if #(.N_CH(1)) if_b ();
    input_conditioner_if #(.N_CH(1)) if_c ();
    input_conditioner #(.N_CH(4), .DEB_LEN(4), .EXT_LEN(4), .EXT_MODE(IC_EXT_RISE))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    input_conditioner #(.N_CH(1), .DEB_LEN(2), .EXT_LEN(3), .EXT_MODE(IC_EXT_BOTH))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    input_conditioner #(.N_CH(1), .DEB_LEN(1), .EXT_LEN(8), .EXT_MODE(IC_EXT_RISE))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    wire [5:0] a_lvl  = {if_c.level, if_b.level, if_a.level};
    wire [5:0] a_rise = {if_c.rise,  if_b.rise,  if_a.rise};
    wire [5:0] a_fall = {if_c.fall,  if_b.fall,  if_a.fall};
    wire [5:0] a_ext  = {if_c.ext,   if_b.ext,   if_a.ext};
    // model: channels 0-3 on dut_a, 4 on dut_b, 5 on dut_c
    int deb  [6] = '{4, 4, 4, 4, 2, 1};
    int extl [6] = '{4, 4, 4, 4, 3, 8};
    int mode [6] = '{0, 0, 0, 0, 1, 0};
    bit raw [6][4096];
    int last_trig [6];
    int n;
    logic [5:0] m_lvl, m_rise, m_fall, m_ext;
    int errors = 0;
    int checks = 0;
    // sample seen by the debouncer at edge index i (raw input delayed by LAT)
    function automatic bit eff(int k, int i);
        return (i >= LAT) ? raw[k][i-LAT] : 1'b0;
    endfunction
    task automatic model_reset();
        n = 0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_ext = '0;
        for (int k = 0; k < 6; k++) last_trig[k] = -1000;
    endtask
    // level flips to v once the last deb samples since reset all equal v;
    // ext is high while fewer than extl edges have passed since the last trigger
    task automatic step();
        logic [5:0] s;
        s = {if_c.in, if_b.in, if_a.in};
        @(posedge clk);
        n++;
        for (int k = 0; k < 6; k++) begin
            bit v, ok;
            raw[k][n-1] = s[k];
            v = eff(k, n - 1);
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (v != m_lvl[k] && n >= deb[k]) begin
                ok = 1'b1;
                for (int i = n - deb[k]; i < n; i++) if (eff(k, i) != v) ok = 1'b0;
                if (ok) begin
                    m_lvl[k]  = v;
                    m_rise[k] = v;
                    m_fall[k] = !v;
                    if (v || mode[k] == IC_EXT_BOTH) last_trig[k] = n;
                end
            end
            m_ext[k] = (n - last_trig[k]) < extl[k];
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        if_a.in = '0; if_b.in = '0; if_c.in = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_lvl, a_rise, a_fall, a_ext} !== 24'h0) begin
            errors++;
            $display("FAIL reset got l/r/f/e=%b/%b/%b/%b exp all 0", a_lvl, a_rise, a_fall, a_ext);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_press();
        do_reset();
        if_a.in = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if ({if_a.level[0], if_a.rise[0], if_a.ext[0]} !== {e >= LAT+4, e == LAT+4, e >= LAT+4 && e <= LAT+7}) begin
                errors++;
                $display("FAIL press e=%0d got l/r/e=%b%b%b exp %b%b%b", e, if_a.level[0], if_a.rise[0], if_a.ext[0],
                         e >= LAT+4, e == LAT+4, e >= LAT+4 && e <= LAT+7);
            end
        end
        if_a.in = '0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if ({a_lvl, a_rise, a_fall, a_ext} !== {m_lvl, m_rise, m_fall, m_ext}) begin
                errors++;
                $display("FAIL press_release n=%0d got l/r/f/e=%b/%b/%b/%b exp %b/%b/%b/%b", n,
                         a_lvl, a_rise, a_fall, a_ext, m_lvl, m_rise, m_fall, m_ext);
            end
        end
    endtask
    task automatic test_glitch();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            if_a.in[1] = e <= 3;
            step();
            checks++;
            if ({if_a.level[1], if_a.rise[1], if_a.ext[1]} !== 3'b000) begin
                errors++;
                $display("FAIL glitch e=%0d got l/r/e=%b%b%b exp 000", e, if_a.level[1], if_a.rise[1], if_a.ext[1]);
            end
        end
        // a 3-long pulse must not combine with a later 1-long pulse: counter cleared
        if_a.in[1] = 1'b1;
        step();
        if_a.in[1] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (if_a.level[1] !== 1'b0 || a_lvl !== m_lvl) begin
                errors++;
                $display("FAIL glitch_clear e=%0d got lvl=%b exp %b", e, a_lvl, m_lvl);
            end
        end
    endtask
    task automatic test_ext_both();
        int falls;
        do_reset();
        falls = 0;
        for (int e = 1; e <= 24; e++) begin
            if_b.in = e <= 10;
            step();
            falls += if_b.fall[0];
            checks++;
            if (if_b.ext[0] !== ((e >= LAT+2 && e <= LAT+4) || (e >= LAT+12 && e <= LAT+14))) begin
                errors++;
                $display("FAIL ext_both e=%0d got ext=%b exp %b", e, if_b.ext[0],
                         (e >= LAT+2 && e <= LAT+4) || (e >= LAT+12 && e <= LAT+14));
            end
        end
        checks++;
        if (falls !== 1) begin
            errors++;
            $display("FAIL ext_both_falls got %0d exp 1", falls);
        end
    endtask
    task automatic test_retrigger();
        int rises;
        do_reset();
        rises = 0;
        for (int e = 1; e <= 20; e++) begin
            if_c.in = (e == 1 || e == 5);
            step();
            rises += if_c.rise[0];
            checks++;
            if (if_c.ext[0] !== (e >= LAT+1 && e <= LAT+12)) begin
                errors++;
                $display("FAIL retrigger e=%0d got ext=%b exp %b", e, if_c.ext[0], e >= LAT+1 && e <= LAT+12);
            end
        end
        checks++;
        if (rises !== 2) begin
            errors++;
            $display("FAIL retrigger_rises got %0d exp 2", rises);
        end
    endtask
    task automatic test_async_reset();
        do_reset();
        if_a.in = 4'b0001;
        for (int e = 1; e <= LAT+5; e++) step();
        checks++;
        if (if_a.ext[0] !== 1'b1 || if_a.level[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got ext/lvl=%b%b exp 11", if_a.ext[0], if_a.level[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_lvl, a_rise, a_fall, a_ext} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset got l/r/f/e=%b/%b/%b/%b exp all 0", a_lvl, a_rise, a_fall, a_ext);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if ({if_a.level[0], if_a.rise[0]} !== {e >= LAT+4, e == LAT+4}) begin
                errors++;
                $display("FAIL async_recover e=%0d got l/r=%b%b exp %b%b", e, if_a.level[0], if_a.rise[0],
                         e >= LAT+4, e == LAT+4);
            end
        end
    endtask
    task automatic test_simultaneous();
        do_reset();
        if_a.in = 4'hF;
        for (int e = 1; e <= 16; e++) begin
            if (e == 9) if_a.in = 4'h0;
            step();
            checks++;
            if ({if_a.level, if_a.rise, if_a.fall, if_a.ext} !==
                {{4{e >= LAT+4 && e < LAT+12}}, {4{e == LAT+4}}, {4{e == LAT+12}}, {4{e >= LAT+4 && e <= LAT+7}}}) begin
                errors++;
                $display("FAIL simultaneous e=%0d got l/r/f/e=%b/%b/%b/%b", e, if_a.level, if_a.rise, if_a.fall, if_a.ext);
            end
        end
    endtask
    task automatic test_random();
        do_reset();
        for (int e = 0; e < 500; e++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(3) == 0) if_a.in[k] = ~if_a.in[k];
            if ($urandom_range(2) == 0) if_b.in = ~if_b.in;
            if ($urandom_range(2) == 0) if_c.in = ~if_c.in;
            step();
            checks++;
            if ({a_lvl, a_rise, a_fall, a_ext} !== {m_lvl, m_rise, m_fall, m_ext}) begin
                errors++;
                $display("FAIL random n=%0d got l/r/f/e=%b/%b/%b/%b exp %b/%b/%b/%b", n,
                         a_lvl, a_rise, a_fall, a_ext, m_lvl, m_rise, m_fall, m_ext);
            end
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        if_a.in = '0; if_b.in = '0; if_c.in = '0;
        model_reset();
        test_reset();
        test_press();
        test_glitch();
        test_ext_both();
        test_retrigger();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter DEB_LEN, default 4: consecutive identical samples required to accept a level change, 1..255.
REQ-003 Parameter EXT_LEN, default 4: ext output stretch length in cycles, 1..255.
REQ-004 Parameter EXT_MODE, default 0: 0 = ext triggers on rise only; 1 = ext triggers on rise and fall.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-high.
REQ-007 in  input  N_CH: raw per-channel inputs (buttons, mouse event strobes).
REQ-008 level  output  N_CH: debounced level per channel.
REQ-009 rise  output  N_CH: one-cycle pulse when level goes 0->1.
REQ-010 fall  output  N_CH: one-cycle pulse when level goes 1->0.
REQ-011 ext  output  N_CH: stretched trigger pulse per channel.

Function
REQ-012 Each channel SHALL be fully independent; no cross-channel state.
REQ-013 Debounce: per-channel counter; on each edge, if sample != level, counter increments, else counter clears to 0.
REQ-014 When the counter would reach DEB_LEN, level SHALL take the sample value and the counter SHALL clear, on that same edge.
REQ-015 Debounce SHALL be symmetric: press and release both need DEB_LEN consecutive samples; DEB_LEN=1 means level follows the sample with 1 edge of latency.
REQ-016 A mismatched glitch shorter than DEB_LEN samples SHALL leave level unchanged and clear the counter.
REQ-017 rise/fall SHALL be registered, asserted exactly in the cycle level first shows its new value, for one cycle only.
REQ-018 ext counter SHALL load EXT_LEN on the edge a trigger (rise, or rise/fall per EXT_MODE) is registered; ext = (counter != 0); counter decrements to 0 and saturates there.
REQ-019 A trigger while ext is active SHALL reload EXT_LEN (retrigger), never add.
REQ-020 ext SHALL be high in the same cycle as the triggering rise/fall pulse and stay high exactly EXT_LEN cycles absent retrigger.
REQ-021 Counter widths SHALL be $clog2(DEB_LEN+1) and $clog2(EXT_LEN+1); no wrap-around is possible.

Reset
REQ-022 On rst assertion, immediately and without clk: level, rise, fall, ext = 0; all counters = 0; synchronizer flops = 0.
REQ-023 Reset mid-debounce or mid-stretch SHALL abandon the operation; after release, an input held at 1 SHALL produce a normal rise after full latency.

Configuration
REQ-024 Macro INPUT_CONDITIONER_SYNC_EN: when defined, each input passes through a 2-flop synchronizer before debounce, adding exactly 2 cycles of latency to level/rise/fall/ext.
REQ-025 Without INPUT_CONDITIONER_SYNC_EN, in SHALL feed the debounce sampler directly; the inputs are then required to be synchronous to clk.

Structure
REQ-026 Shared package ic_pkg SHALL hold default constants IC_N_CH, IC_DEB_LEN, IC_EXT_LEN and the EXT_MODE encodings (IC_EXT_RISE=0, IC_EXT_BOTH=1).
REQ-027 One sub-module ic_channel (single-channel sync/debounce/edge/stretch) SHALL be instantiated N_CH times via generate; the top contains only the generate loop.

Verification
REQ-028 Defaults, no sync: in[0] 0->1 held → level[0]=1 and rise[0]=1 at the 4th edge; ext[0] high for cycles 4..7; rise low from cycle 5.
REQ-029 in[1] high for 3 cycles then low → level, rise and ext on channel 1 stay 0; counter returns to 0.
REQ-030 EXT_MODE=1, DEB_LEN=2, EXT_LEN=3: press held 10 cycles then released → ext high 3 cycles after the rise and 3 cycles after the fall; fall pulses for one cycle.
REQ-031 Retrigger: EXT_LEN=8, DEB_LEN=1, two rises 4 cycles apart → ext continuously high for 12 cycles.
REQ-032 rst asserted asynchronously mid-stretch with in=1 → all outputs 0 before the next clk edge; after release, rise after 4 edges.
REQ-033 INPUT_CONDITIONER_SYNC_EN defined, repeat REQ-028 → every event shifted exactly 2 cycles later; all channels toggled simultaneously → identical independent responses.
